// File: rtl/csi2_pkt_handler_pkg.sv
// Shared types and constants for the CSI-2 packet handler: FSM states,
// data-type codes, CRC parameters and header field positions.
package csi2_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CRC_TAIL,
    ST_DONE
  } state_e;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;

  localparam int HDR_DT_LSB  = 0;
  localparam int HDR_DT_MSB  = 5;
  localparam int HDR_VC_LSB  = 6;
  localparam int HDR_VC_MSB  = 7;
  localparam int HDR_WC_LSB  = 8;
  localparam int HDR_WC_MSB  = 23;
  localparam int HDR_ECC_LSB = 24;
  localparam int HDR_ECC_MSB = 31;

  // Contiguous byte-enable mask for the given number of low-order bytes.
  function automatic logic [3:0] keep_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/csi2_pkt_handler_if.sv
// Word stream from the header ECC decoder into the packet handler.
interface csi2_pkt_handler_if;
  logic        valid;
  logic [31:0] data;
  logic        error;
  logic        error_corrected;

  modport master (output valid, data, error, error_corrected);
  modport slave  (input  valid, data, error, error_corrected);
endinterface

// File: rtl/csi2_pkt_handler_crc16.sv
// Combinational CSI-2 CRC-16 update over up to four bytes, LSB byte first,
// only bytes whose keep bit is set are folded in.
module csi2_crc16
  import csi2_pkt_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  keep,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int b = 0; b < 4; b++) begin
      if (keep[b]) begin
        c = c ^ {8'h00, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/csi2_pkt_handler.sv
// CSI-2 packet handler: splits short/long packets, emits payload with keep/last,
// checks the CRC-16 footer and pulses pkt_done for upstream re-arm.
//   state       | meaning
//   ST_IDLE     | waiting for a packet header word
//   ST_PAYLOAD  | long packet payload words (last one may carry the footer)
//   ST_CRC_TAIL | one word holding the remaining footer bytes
//   ST_DONE     | pkt_done pulse, input discarded
module csi2_pkt_handler
  import csi2_pkt_pkg::*;
#(
  parameter bit         CRC_EN       = 1'b1,
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  csi2_pkt_handler_if.slave         dec_if,
  output logic                      pkt_done_o,
  output logic                      sp_valid_o,
  output logic [5:0]                sp_dt_o,
  output logic [1:0]                sp_vc_o,
  output logic [15:0]               sp_data_o,
  output logic                      pkt_valid_o,
  output logic [31:0]               pkt_data_o,
  output logic [3:0]                pkt_keep_o,
  output logic                      pkt_last_o,
  output logic [5:0]                pkt_dt_o,
  output logic [1:0]                pkt_vc_o,
  output logic                      crc_valid_o,
  output logic                      crc_err_o,
  output logic                      header_err_o,
  output logic                      ecc_corr_o
);

  state_e      state_q, state_d;
  logic [15:0] bytes_left_q, bytes_left_d;
  logic [14:0] words_left_q, words_left_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        crc_split_q, crc_split_d;

  logic        pkt_done_q, pkt_done_d;
  logic        sp_valid_q, sp_valid_d;
  logic [5:0]  sp_dt_q, sp_dt_d;
  logic [1:0]  sp_vc_q, sp_vc_d;
  logic [15:0] sp_data_q, sp_data_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [31:0] pkt_data_q, pkt_data_d;
  logic [3:0]  pkt_keep_q, pkt_keep_d;
  logic        pkt_last_q, pkt_last_d;
  logic [5:0]  pkt_dt_q, pkt_dt_d;
  logic [1:0]  pkt_vc_q, pkt_vc_d;
  logic        crc_valid_q, crc_valid_d;
  logic        crc_err_q, crc_err_d;
  logic        header_err_q, header_err_d;
  logic        ecc_corr_q, ecc_corr_d;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic [2:0]  nb;
  logic [3:0]  pay_keep;
  logic [15:0] crc_next;
  logic [15:0] rx_crc_pay;
  logic [15:0] rx_crc_tail;

  assign hdr_dt = dec_if.data[HDR_DT_MSB:HDR_DT_LSB];
  assign hdr_vc = dec_if.data[HDR_VC_MSB:HDR_VC_LSB];
  assign hdr_wc = dec_if.data[HDR_WC_MSB:HDR_WC_LSB];

  assign nb       = (bytes_left_q >= 16'd4) ? 3'd4 : bytes_left_q[2:0];
  assign pay_keep = keep_mask(nb);

  // Footer starts right after the payload bytes of the word.
  always_comb begin
    case (nb)
      3'd0:    rx_crc_pay = dec_if.data[15:0];
      3'd1:    rx_crc_pay = dec_if.data[23:8];
      default: rx_crc_pay = dec_if.data[31:16];
    endcase
  end

  assign rx_crc_tail = crc_split_q ? {dec_if.data[7:0], crc_lo_q} : dec_if.data[15:0];

  csi2_crc16 u_crc (
    .crc_in  (crc_q),
    .data    (dec_if.data),
    .keep    (pay_keep),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    crc_d        = crc_q;
    crc_lo_d     = crc_lo_q;
    crc_split_d  = crc_split_q;
    pkt_done_d   = 1'b0;
    sp_valid_d   = 1'b0;
    sp_dt_d      = sp_dt_q;
    sp_vc_d      = sp_vc_q;
    sp_data_d    = sp_data_q;
    pkt_valid_d  = 1'b0;
    pkt_data_d   = pkt_data_q;
    pkt_keep_d   = 4'b0000;
    pkt_last_d   = 1'b0;
    pkt_dt_d     = pkt_dt_q;
    pkt_vc_d     = pkt_vc_q;
    crc_valid_d  = 1'b0;
    crc_err_d    = 1'b0;
    header_err_d = 1'b0;
    ecc_corr_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dec_if.valid) begin
          state_d = ST_DONE;
          if (dec_if.error && !dec_if.error_corrected) begin
            header_err_d = 1'b1;
          end else begin
            ecc_corr_d = dec_if.error_corrected;
            if (hdr_dt <= SHORT_DT_MAX) begin
              sp_valid_d = 1'b1;
              sp_dt_d    = hdr_dt;
              sp_vc_d    = hdr_vc;
              sp_data_d  = hdr_wc;
            end else begin
              state_d      = ST_PAYLOAD;
              pkt_dt_d     = hdr_dt;
              pkt_vc_d     = hdr_vc;
              bytes_left_d = hdr_wc;
              words_left_d = 15'(({1'b0, hdr_wc} + 17'd5) >> 2);
              crc_d        = CRC_INIT;
              crc_split_d  = 1'b0;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (dec_if.valid) begin
          pkt_valid_d  = (nb != 3'd0);
          pkt_data_d   = dec_if.data;
          pkt_keep_d   = pay_keep;
          pkt_last_d   = (nb != 3'd0) && (bytes_left_q <= 16'd4);
          crc_d        = crc_next;
          bytes_left_d = bytes_left_q - 16'(nb);
          words_left_d = words_left_q - 15'd1;
          if (words_left_q == 15'd1) begin
            state_d     = ST_DONE;
            crc_valid_d = CRC_EN;
            crc_err_d   = CRC_EN && (rx_crc_pay != crc_next);
          end else if (bytes_left_q <= 16'd4) begin
            // WC mod 4 == 3 leaves the low CRC byte in byte 3 of this word.
            state_d     = ST_CRC_TAIL;
            crc_split_d = (nb == 3'd3);
            crc_lo_d    = dec_if.data[31:24];
          end
        end
      end
      ST_CRC_TAIL: begin
        if (dec_if.valid) begin
          state_d     = ST_DONE;
          crc_valid_d = CRC_EN;
          crc_err_d   = CRC_EN && (rx_crc_tail != crc_q);
        end
      end
      ST_DONE: begin
        pkt_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bytes_left_q <= '0;
      words_left_q <= '0;
      crc_q        <= CRC_INIT;
      crc_lo_q     <= '0;
      crc_split_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      sp_valid_q   <= 1'b0;
      sp_dt_q      <= '0;
      sp_vc_q      <= '0;
      sp_data_q    <= '0;
      pkt_valid_q  <= 1'b0;
      pkt_data_q   <= '0;
      pkt_keep_q   <= '0;
      pkt_last_q   <= 1'b0;
      pkt_dt_q     <= '0;
      pkt_vc_q     <= '0;
      crc_valid_q  <= 1'b0;
      crc_err_q    <= 1'b0;
      header_err_q <= 1'b0;
      ecc_corr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      crc_q        <= crc_d;
      crc_lo_q     <= crc_lo_d;
      crc_split_q  <= crc_split_d;
      pkt_done_q   <= pkt_done_d;
      sp_valid_q   <= sp_valid_d;
      sp_dt_q      <= sp_dt_d;
      sp_vc_q      <= sp_vc_d;
      sp_data_q    <= sp_data_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_data_q   <= pkt_data_d;
      pkt_keep_q   <= pkt_keep_d;
      pkt_last_q   <= pkt_last_d;
      pkt_dt_q     <= pkt_dt_d;
      pkt_vc_q     <= pkt_vc_d;
      crc_valid_q  <= crc_valid_d;
      crc_err_q    <= crc_err_d;
      header_err_q <= header_err_d;
      ecc_corr_q   <= ecc_corr_d;
    end
  end

  assign pkt_done_o   = pkt_done_q;
  assign sp_valid_o   = sp_valid_q;
  assign sp_dt_o      = sp_dt_q;
  assign sp_vc_o      = sp_vc_q;
  assign sp_data_o    = sp_data_q;
  assign pkt_valid_o  = pkt_valid_q;
  assign pkt_data_o   = pkt_data_q;
  assign pkt_keep_o   = pkt_keep_q;
  assign pkt_last_o   = pkt_last_q;
  assign pkt_dt_o     = pkt_dt_q;
  assign pkt_vc_o     = pkt_vc_q;
  assign crc_valid_o  = crc_valid_q;
  assign crc_err_o    = crc_err_q;
  assign header_err_o = header_err_q;
  assign ecc_corr_o   = ecc_corr_q;

endmodule

// File: tb/tb_csi2_pkt_handler.sv
// Bench for csi2_pkt_handler: packet-level reference model builds expected
// output events (tagged with cycle) which are compared to monitored events.
module tb_csi2_pkt_handler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csi2_pkt_handler_if dec_if ();

  logic        pkt_done_o, sp_valid_o, pkt_valid_o, pkt_last_o;
  logic        crc_valid_o, crc_err_o, header_err_o, ecc_corr_o;
  logic [5:0]  sp_dt_o, pkt_dt_o;
  logic [1:0]  sp_vc_o, pkt_vc_o;
  logic [15:0] sp_data_o;
  logic [31:0] pkt_data_o;
  logic [3:0]  pkt_keep_o;

  csi2_pkt_handler dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dec_if       (dec_if),
    .pkt_done_o   (pkt_done_o),
    .sp_valid_o   (sp_valid_o),
    .sp_dt_o      (sp_dt_o),
    .sp_vc_o      (sp_vc_o),
    .sp_data_o    (sp_data_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_data_o   (pkt_data_o),
    .pkt_keep_o   (pkt_keep_o),
    .pkt_last_o   (pkt_last_o),
    .pkt_dt_o     (pkt_dt_o),
    .pkt_vc_o     (pkt_vc_o),
    .crc_valid_o  (crc_valid_o),
    .crc_err_o    (crc_err_o),
    .header_err_o (header_err_o),
    .ecc_corr_o   (ecc_corr_o)
  );

  typedef struct packed {
    logic [15:0] cyc;
    logic [2:0]  kind;
    logic [31:0] a;
    logic [3:0]  b;
    logic        c;
    logic [7:0]  d;
  } ev_t;

  localparam logic [2:0] K_PW = 3'd0, K_SP = 3'd1, K_CRC = 3'd2, K_DONE = 3'd3,
                         K_HERR = 3'd4, K_ECC = 3'd5;

  ev_t        mon_q[$];
  ev_t        exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] strm[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input logic [2:0] k, input logic [31:0] a,
                             input logic [3:0] b, input logic l, input logic [7:0] d);
    ev_t e;
    e.cyc = c[15:0]; e.kind = k; e.a = a; e.b = b; e.c = l; e.d = d;
    return e;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Bit-serial reflected CRC-16 over the payload byte queue.
  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pay[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ pay[i][j];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (pkt_valid_o || pkt_last_o)
      mon_q.push_back(mk(cyc, K_PW, pkt_data_o & bmask(pkt_keep_o), pkt_keep_o, pkt_last_o,
                         {pkt_vc_o, pkt_dt_o}));
    if (sp_valid_o)
      mon_q.push_back(mk(cyc, K_SP, {16'h0000, sp_data_o}, 4'h0, 1'b0, {sp_vc_o, sp_dt_o}));
    if (crc_valid_o || crc_err_o)
      mon_q.push_back(mk(cyc, K_CRC, 32'h0, 4'h0, crc_err_o, {7'h00, crc_valid_o}));
    if (pkt_done_o)   mon_q.push_back(mk(cyc, K_DONE, 32'h0, 4'h0, 1'b0, 8'h00));
    if (header_err_o) mon_q.push_back(mk(cyc, K_HERR, 32'h0, 4'h0, 1'b0, 8'h00));
    if (ecc_corr_o)   mon_q.push_back(mk(cyc, K_ECC, 32'h0, 4'h0, 1'b0, 8'h00));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dec_if.valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive(input logic [31:0] d, input logic e, input logic c, output int k);
    dec_if.valid = 1'b1; dec_if.data = d; dec_if.error = e; dec_if.error_corrected = c;
    k = cyc;
    tick();
    dec_if.valid = 1'b0; dec_if.error = 1'b0; dec_if.error_corrected = 1'b0;
  endtask

  task automatic send_short(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                            input logic corr);
    int k;
    drive({8'($urandom), wc, vc, dt}, corr, corr, k);
    exp_q.push_back(mk(k + 1, K_SP, {16'h0000, wc}, 4'h0, 1'b0, {vc, dt}));
    if (corr) exp_q.push_back(mk(k + 1, K_ECC, 32'h0, 4'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(k + 2, K_DONE, 32'h0, 4'h0, 1'b0, 8'h00));
    idle(1);
  endtask

  task automatic send_herr(input logic [5:0] dt, input logic [15:0] wc);
    int k;
    drive({8'($urandom), wc, 2'($urandom), dt}, 1'b1, 1'b0, k);
    exp_q.push_back(mk(k + 1, K_HERR, 32'h0, 4'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(k + 2, K_DONE, 32'h0, 4'h0, 1'b0, 8'h00));
    idle(1);
  endtask

  // Long packet: header, payload+CRC+padding words with random gaps, then
  // either an idle cycle or a junk word during the done cycle.
  task automatic send_long(input logic [5:0] dt, input logic [1:0] vc, input int wc,
                           input logic corr, input logic bad, input int maxgap, input logic junk);
    int k, nw, nbytes;
    logic [15:0] crc;
    logic [31:0] w;
    pay.delete(); strm.delete();
    for (int i = 0; i < wc; i++) pay.push_back(8'($urandom));
    crc = crc_ref();
    if (bad) crc = crc ^ (16'h0001 << $urandom_range(0, 15));
    foreach (pay[i]) strm.push_back(pay[i]);
    strm.push_back(crc[7:0]);
    strm.push_back(crc[15:8]);
    while (strm.size() % 4 != 0) strm.push_back(8'($urandom));
    nw = strm.size() / 4;
    drive({8'($urandom), 16'(wc), vc, dt}, corr, corr, k);
    if (corr) exp_q.push_back(mk(k + 1, K_ECC, 32'h0, 4'h0, 1'b0, 8'h00));
    for (int i = 0; i < nw; i++) begin
      idle($urandom_range(0, maxgap));
      w = {strm[4*i+3], strm[4*i+2], strm[4*i+1], strm[4*i]};
      drive(w, 1'b0, 1'b0, k);
      nbytes = wc - 4 * i;
      if (nbytes > 4) nbytes = 4;
      if (nbytes > 0) begin
        exp_q.push_back(mk(k + 1, K_PW, w & bmask((4'hF >> (4 - nbytes))),
                           4'hF >> (4 - nbytes), (wc <= 4 * i + 4), {vc, dt}));
      end
      if (i == nw - 1) begin
        exp_q.push_back(mk(k + 1, K_CRC, 32'h0, 4'h0, bad, 8'h01));
        exp_q.push_back(mk(k + 2, K_DONE, 32'h0, 4'h0, 1'b0, 8'h00));
      end
    end
    if (junk) drive($urandom, 1'($urandom), 1'($urandom), k);
    else idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++;
    if ({pkt_done_o, sp_valid_o, sp_dt_o, sp_vc_o, sp_data_o, pkt_valid_o, pkt_data_o, pkt_keep_o,
         pkt_last_o, pkt_dt_o, pkt_vc_o, crc_valid_o, crc_err_o, header_err_o, ecc_corr_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got nonzero outputs (pkt_valid=%b sp_valid=%b done=%b) exp all 0",
               pkt_valid_o, sp_valid_o, pkt_done_o);
    end
    rst = 1'b0;
    tick();
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_short();
    int k;
    ev_t g;
    drive(32'h0000_0100, 1'b0, 1'b0, k);
    exp_q.push_back(mk(k + 1, K_SP, 32'h0000_0001, 4'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(k + 2, K_DONE, 32'h0, 4'h0, 1'b0, 8'h00));
    idle(1);
    for (int i = 0; i < 8; i++) send_short(6'($urandom_range(0, 15)), 2'($urandom), 16'($urandom), 1'($urandom));
    idle(3);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++; $display("FAIL short count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0; if (i < mon_q.size()) g = mon_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL short ev%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_long_fixed();
    ev_t g;
    send_long(6'h2B, 2'd0, 10, 1'b0, 1'b0, 0, 1'b0);
    send_long(6'h2B, 2'd1, 8, 1'b0, 1'b0, 0, 1'b0);
    for (int wc = 0; wc <= 6; wc++) send_long(6'h24, 2'd2, wc, 1'b0, 1'b0, 0, 1'b0);
    idle(3);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++; $display("FAIL long_fixed count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0; if (i < mon_q.size()) g = mon_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL long_fixed ev%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_crc_err();
    ev_t g;
    send_long(6'h2B, 2'd3, 10, 1'b0, 1'b1, 0, 1'b0);
    send_long(6'h2B, 2'd3, 7, 1'b0, 1'b1, 0, 1'b0);
    send_long(6'h2B, 2'd3, 12, 1'b0, 1'b1, 0, 1'b0);
    idle(3);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++; $display("FAIL crc_err count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0; if (i < mon_q.size()) g = mon_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL crc_err ev%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_header_err();
    ev_t g;
    send_herr(6'h2B, 16'd10);
    send_long(6'h2B, 2'd1, 10, 1'b1, 1'b0, 0, 1'b0);
    send_herr(6'h01, 16'd3);
    send_short(6'h01, 2'd2, 16'h00A5, 1'b1);
    idle(3);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++; $display("FAIL header_err count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0; if (i < mon_q.size()) g = mon_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL header_err ev%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t g;
    int sel;
    for (int p = 0; p < 30; p++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) send_short(6'($urandom_range(0, 15)), 2'($urandom), 16'($urandom), 1'($urandom));
      else if (sel == 2) send_herr(6'($urandom), 16'($urandom_range(0, 40)));
      else send_long(6'($urandom_range(16, 63)), 2'($urandom), $urandom_range(0, 40),
                     1'($urandom), ($urandom_range(0, 3) == 0), 2, 1'($urandom));
    end
    idle(3);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++; $display("FAIL back_to_back count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0; if (i < mon_q.size()) g = mon_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL back_to_back ev%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_gaps_reset();
    ev_t g;
    int k;
    logic [31:0] w;
    send_long(6'h2A, 2'd1, 7, 1'b0, 1'b0, 3, 1'b0);
    drive({8'h00, 16'd20, 2'd2, 6'h2B}, 1'b0, 1'b0, k);
    w = $urandom;
    drive(w, 1'b0, 1'b0, k);
    exp_q.push_back(mk(k + 1, K_PW, w, 4'hF, 1'b0, {2'd2, 6'h2B}));
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({pkt_done_o, sp_valid_o, sp_dt_o, sp_vc_o, sp_data_o, pkt_valid_o, pkt_data_o, pkt_keep_o,
         pkt_last_o, pkt_dt_o, pkt_vc_o, crc_valid_o, crc_err_o, header_err_o, ecc_corr_o} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got nonzero outputs (pkt_valid=%b last=%b dt=%h) exp all 0",
               pkt_valid_o, pkt_last_o, pkt_dt_o);
    end
    rst = 1'b0;
    tick();
    send_long(6'h2C, 2'd3, 7, 1'b0, 1'b0, 3, 1'b0);
    send_short(6'h00, 2'd0, 16'h0001, 1'b0);
    idle(3);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++; $display("FAIL gaps_reset count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0; if (i < mon_q.size()) g = mon_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL gaps_reset ev%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  initial begin
    dec_if.valid = 1'b0;
    dec_if.data = '0;
    dec_if.error = 1'b0;
    dec_if.error_corrected = 1'b0;
    tick();
    test_reset();
    test_short();
    test_long_fixed();
    test_crc_err();
    test_header_err();
    test_back_to_back();
    test_gaps_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
